// File: rtl/hog_pkg.sv
// Shared constants and types for the HOG cell-histogram stage.
package hog_pkg;

    // Default geometry of one HOG cell and its histogram.
    localparam int HOG_CODE_W  = 4;
    localparam int HOG_MAG_W   = 12;
    localparam int HOG_CNT_W   = 6;
    localparam int HOG_MAX_CNT = 64;
    localparam int HOG_NBINS   = 9;

    // Accumulator is wide enough that a full cell of full-scale magnitudes never wraps.
    localparam int HOG_BIN_W   = HOG_MAG_W + HOG_CNT_W;

    // Controller states: gather pixels, then stream the finished histogram out.
    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } state_e;

endpackage

// File: rtl/hist_bin_bank.sv
// NBINS x BIN_W accumulator register file with one indexed add port,
// one combinational read port and a synchronous clear-all.
module hist_bin_bank #(
    parameter int NBINS = 9,
    parameter int BIN_W = 18,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             add_en,
    input  logic [IDX_W-1:0] add_idx,
    input  logic [BIN_W-1:0] addend,
    input  logic [IDX_W-1:0] ridx,
    output logic [BIN_W-1:0] rdata
);

    logic [BIN_W-1:0] bins_r [NBINS];
    logic [BIN_W-1:0] rdata_s;

    // Per-bin accumulate; reset and clear both zero every bin, reset wins.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NBINS; b++) begin
            if (rst) begin
                bins_r[b] <= '0;
            end else if (clr) begin
                bins_r[b] <= '0;
            end else if (add_en && (add_idx == IDX_W'(b))) begin
                bins_r[b] <= bins_r[b] + addend;
            end else begin
                bins_r[b] <= bins_r[b];
            end
        end
    end

    // Read mux; an index outside the bank reads as zero.
    always_comb begin
        rdata_s = '0;
        for (int b = 0; b < NBINS; b++) begin
            if (ridx == IDX_W'(b)) begin
                rdata_s = bins_r[b];
            end else begin
                rdata_s = rdata_s;
            end
        end
    end

    assign rdata = rdata_s;

endmodule

// File: rtl/cell_hist_ctrl.sv
// Cell histogram controller: accumulates a 9-bin orientation histogram over
// one cell of pixels, then stalls the input and drains the bins serially.
module cell_hist_ctrl
    import hog_pkg::*;
#(
    parameter int CODE_W  = HOG_CODE_W,
    parameter int MAG_W   = HOG_MAG_W,
    parameter int CNT_W   = HOG_CNT_W,
    parameter int MAX_CNT = HOG_MAX_CNT,
    parameter int NBINS   = HOG_NBINS,
    parameter int BIN_W   = HOG_BIN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic [CODE_W-1:0] i_code,
    input  logic [MAG_W-1:0]  i_mag,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [CODE_W-1:0] o_bin_idx,
    output logic [BIN_W-1:0]  o_bin_val,
    output logic              o_last,
    output logic [CNT_W-1:0]  cnt,
    output logic              err_code
);

    // Geometry sanity: accumulator must hold a full cell at full scale,
    // the counter must reach MAX_CNT-1 and the code must address every bin.
    if (BIN_W < MAG_W + CNT_W) begin : g_bin_w_check
        $error("cell_hist_ctrl: BIN_W too narrow for MAG_W+CNT_W");
    end
    if (MAX_CNT > (2 ** CNT_W)) begin : g_cnt_w_check
        $error("cell_hist_ctrl: CNT_W too narrow for MAX_CNT");
    end
    if (NBINS > (2 ** CODE_W)) begin : g_code_w_check
        $error("cell_hist_ctrl: CODE_W too narrow for NBINS");
    end

    localparam logic [CNT_W-1:0]  LAST_PIX = CNT_W'(MAX_CNT - 1);
    localparam logic [CODE_W-1:0] LAST_BIN = CODE_W'(NBINS - 1);
    localparam logic [CODE_W-1:0] NBINS_C  = CODE_W'(NBINS);

    state_e              state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [CODE_W-1:0]   idx_r;
    logic                err_r;

    logic                accum_s;
    logic                drain_s;
    logic                accept_s;
    logic                code_ok_s;
    logic                add_en_s;
    logic [BIN_W-1:0]    addend_s;
    logic                last_pix_s;
    logic                last_beat_s;
    logic                beat_s;
    logic                clr_s;
    logic [BIN_W-1:0]    rdata_s;
    logic [BIN_W-1:0]    bin_val_s;

    // Handshake and event decode; ready/valid depend on registered state only.
    always_comb begin
        accum_s     = (state_r == ACCUM);
        drain_s     = (state_r == DRAIN);
        accept_s    = i_valid && accum_s;
        code_ok_s   = (i_code < NBINS_C);
        add_en_s    = accept_s && code_ok_s;
        addend_s    = {{(BIN_W - MAG_W){1'b0}}, i_mag};
        last_pix_s  = (cnt_r == LAST_PIX);
        last_beat_s = (idx_r == LAST_BIN);
        beat_s      = drain_s && o_ready;
        clr_s       = beat_s && last_beat_s;
    end

    // Controller FSM, pixel counter, drain index and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ACCUM;
            cnt_r   <= '0;
            idx_r   <= '0;
            err_r   <= 1'b0;
        end else begin
            case (state_r)
                ACCUM: begin
                    if (accept_s) begin
                        err_r <= err_r | ~code_ok_s;
                        if (last_pix_s) begin
                            cnt_r   <= '0;
                            idx_r   <= '0;
                            state_r <= DRAIN;
                        end else begin
                            cnt_r   <= cnt_r + CNT_W'(1);
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                DRAIN: begin
                    if (beat_s) begin
                        if (last_beat_s) begin
                            idx_r   <= '0;
                            state_r <= ACCUM;
                        end else begin
                            idx_r   <= idx_r + CODE_W'(1);
                        end
                    end else begin
                        idx_r <= idx_r;
                    end
                end
                default: begin
                    state_r <= ACCUM;
                    cnt_r   <= '0;
                    idx_r   <= '0;
                end
            endcase
        end
    end

    hist_bin_bank #(
        .NBINS (NBINS),
        .BIN_W (BIN_W),
        .IDX_W (CODE_W)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr_s),
        .add_en  (add_en_s),
        .add_idx (i_code),
        .addend  (addend_s),
        .ridx    (idx_r),
        .rdata   (rdata_s)
    );

    // Bin value is only presented while draining so the bus idles at zero.
    always_comb begin
        if (drain_s) begin
            bin_val_s = rdata_s;
        end else begin
            bin_val_s = '0;
        end
    end

    assign i_ready   = accum_s;
    assign o_valid   = drain_s;
    assign o_bin_idx = idx_r;
    assign o_bin_val = bin_val_s;
    assign o_last    = drain_s && last_beat_s;
    assign cnt       = cnt_r;
    assign err_code  = err_r;

endmodule

// File: tb/tb_cell_hist_ctrl.sv
// Self-checking bench for cell_hist_ctrl: a cell-level histogram model checked
// every cycle, plus hand-computed bin values for each directed scenario.
module tb_cell_hist_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_ready;
    logic [3:0]  i_code = 4'd0;
    logic [11:0] i_mag = 12'd0;
    logic        o_valid;
    logic        o_ready = 1'b1;
    logic [3:0]  o_bin_idx;
    logic [17:0] o_bin_val;
    logic        o_last;
    logic [5:0]  cnt;
    logic        err_code;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Cell-level model: bins collected per pixel, snapshot served beat by beat.
    int  m_bins [9];
    int  m_snap [9];
    int  m_cnt = 0;
    bit  m_err = 1'b0;
    bit  m_drain = 1'b0;
    int  m_beat = 0;

    // Values actually delivered by the DUT, and beat handshake count.
    int  dut_beat [9];
    int  beats_seen = 0;

    cell_hist_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .i_ready   (i_ready),
        .i_code    (i_code),
        .i_mag     (i_mag),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_bin_idx (o_bin_idx),
        .o_bin_val (o_bin_val),
        .o_last    (o_last),
        .cnt       (cnt),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tmo(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timeout waiting on DUT at %0t", nm, $time);
    endtask

    // Per-cycle compare against the model, then advance the model for the coming edge.
    initial begin
        for (int b = 0; b < 9; b++) begin
            m_bins[b] = 0;
            m_snap[b] = 0;
            dut_beat[b] = 0;
        end
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("i_ready",   32'(i_ready),   32'(!m_drain));
                chk("o_valid",   32'(o_valid),   32'(m_drain));
                chk("o_last",    32'(o_last),    32'(m_drain && (m_beat == 8)));
                chk("o_bin_idx", 32'(o_bin_idx), m_drain ? 32'(m_beat) : 32'd0);
                chk("o_bin_val", 32'(o_bin_val), m_drain ? 32'(m_snap[m_beat]) : 32'd0);
                chk("cnt",       32'(cnt),       32'(m_cnt));
                chk("err_code",  32'(err_code),  32'(m_err));
                if (o_valid && o_ready) begin
                    beats_seen++;
                    if (o_bin_idx < 4'd9) dut_beat[o_bin_idx] = 32'(o_bin_val);
                end
            end
            if (rst) begin
                for (int b = 0; b < 9; b++) m_bins[b] = 0;
                m_cnt = 0;
                m_err = 1'b0;
                m_drain = 1'b0;
                m_beat = 0;
            end else if (!m_drain) begin
                if (i_valid) begin
                    if (i_code < 4'd9) m_bins[i_code] += int'(i_mag);
                    else m_err = 1'b1;
                    m_cnt++;
                    if (m_cnt == 64) begin
                        for (int b = 0; b < 9; b++) begin
                            m_snap[b] = m_bins[b];
                            m_bins[b] = 0;
                        end
                        m_cnt = 0;
                        m_drain = 1'b1;
                        m_beat = 0;
                    end
                end
            end else if (o_ready) begin
                if (m_beat == 8) m_drain = 1'b0;
                else m_beat++;
            end
        end
    end

    // Present one pixel and hold it until the DUT takes it.
    task automatic send(input logic [3:0] c, input logic [11:0] m);
        bit acc;
        int t;
        i_valid = 1'b1;
        i_code  = c;
        i_mag   = m;
        t = 0;
        do begin
            acc = i_ready;
            @(posedge clk);
            #2;
            t++;
        end while (!acc && t < 100);
        if (!acc) tmo("send");
    endtask

    // Wait for the controller to come back to accepting pixels.
    task automatic wait_ready(output int cycles, input bit toggle);
        cycles = 0;
        while (!i_ready && cycles < 200) begin
            if (toggle) o_ready = ~o_ready;
            @(posedge clk);
            #2;
            cycles++;
        end
        o_ready = 1'b1;
        if (!i_ready) tmo("wait_ready");
    endtask

    task automatic clear_capture();
        for (int b = 0; b < 9; b++) dut_beat[b] = -1;
    endtask

    int cyc;
    int beats0;

    initial begin
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset_i_ready", 32'(i_ready), 32'd1);
        chk("reset_o_valid", 32'(o_valid), 32'd0);
        chk("reset_cnt",     32'(cnt),     32'd0);
        chk("reset_err",     32'(err_code), 32'd0);
        chk("reset_val",     32'(o_bin_val), 32'd0);

        // Uniform cell: code 0, mag 1, i_valid held through the drain.
        clear_capture();
        beats0 = beats_seen;
        for (int k = 0; k < 64; k++) send(4'd0, 12'd1);
        chk("t1_ready_drop", 32'(i_ready), 32'd0);
        wait_ready(cyc, 1'b0);
        chk("t1_drain_cycles", 32'(cyc), 32'd9);
        chk("t1_beats", 32'(beats_seen - beats0), 32'd9);
        chk("t1_bin0", 32'(dut_beat[0]), 32'd64);
        chk("t1_bin4", 32'(dut_beat[4]), 32'd0);
        chk("t1_bin8", 32'(dut_beat[8]), 32'd0);
        chk("t1_model_bin0", 32'(m_snap[0]), 32'd64);
        i_valid = 1'b0;

        // Full-scale: code 8, mag 4095 for a whole cell.
        clear_capture();
        for (int k = 0; k < 64; k++) send(4'd8, 12'd4095);
        i_valid = 1'b0;
        wait_ready(cyc, 1'b0);
        chk("t2_bin8", 32'(dut_beat[8]), 32'd262080);
        chk("t2_bin0", 32'(dut_beat[0]), 32'd0);

        // Mixed codes with alternating backpressure.
        clear_capture();
        beats0 = beats_seen;
        for (int k = 0; k < 64; k++) send(4'(k % 9), 12'(k));
        i_valid = 1'b0;
        o_ready = 1'b1;
        wait_ready(cyc, 1'b1);
        chk("t3_beats", 32'(beats_seen - beats0), 32'd9);
        chk("t3_bin0", 32'(dut_beat[0]), 32'd252);
        chk("t3_bin1", 32'(dut_beat[1]), 32'd196);
        chk("t3_bin8", 32'(dut_beat[8]), 32'd245);

        // Illegal code in the middle of a cell.
        clear_capture();
        for (int k = 0; k < 64; k++) begin
            if (k == 10) send(4'd9, 12'd100);
            else send(4'd1, 12'd2);
            if (k == 10) chk("t4_err_next", 32'(err_code), 32'd1);
        end
        i_valid = 1'b0;
        wait_ready(cyc, 1'b0);
        chk("t4_bin1", 32'(dut_beat[1]), 32'd126);
        chk("t4_err_sticky", 32'(err_code), 32'd1);

        // Reset mid-cell after 30 pixels, then a fresh cell.
        for (int k = 0; k < 30; k++) send(4'd5, 12'd9);
        i_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        chk("t5_cnt", 32'(cnt), 32'd0);
        chk("t5_err", 32'(err_code), 32'd0);
        chk("t5_ready", 32'(i_ready), 32'd1);
        clear_capture();
        for (int k = 0; k < 64; k++) send(4'd3, 12'd7);
        i_valid = 1'b0;
        wait_ready(cyc, 1'b0);
        chk("t5_bin3", 32'(dut_beat[3]), 32'd448);
        chk("t5_bin5", 32'(dut_beat[5]), 32'd0);

        // Back-to-back cells streamed continuously.
        clear_capture();
        beats0 = beats_seen;
        for (int k = 0; k < 128; k++) send(4'd2, (k < 64) ? 12'd10 : 12'd1);
        i_valid = 1'b0;
        wait_ready(cyc, 1'b0);
        chk("t6_beats", 32'(beats_seen - beats0), 32'd18);
        chk("t6_bin2", 32'(dut_beat[2]), 32'd64);

        repeat (3) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
